mem_step_checker: RTL

MEM_STEP_CHECKER -- requirements
Module: mem_step_checker

---
 rtl/mem_check_pkg.sv | 17 +
 rtl/tick_edge.sv | 28 ++
 rtl/mem_step_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_check_pkg.sv
// Shared definitions for the stepped memory checker.
//   state_t      : sweep controller states
//   DEFAULT_SEED : default pattern key; the expected word at an address is
//                  the zero-extended address XOR this key
package mem_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for the divided step clock.
//   CLK      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   level_in : slow level signal, synchronous to CLK
//   rise_out : one-CLK pulse when level_in goes from 0 to 1
module tick_edge (
  input  logic CLK,
  input  logic rst_n,
  input  logic level_in,
  output logic rise_out
);

  logic r_level_q;

  // The divider output also resets high, so the history register resets
  // to 1 as well; a level that is already high at reset release must not
  // look like a fresh rising edge.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_level_q <= 1'b1;
    end else begin
      r_level_q <= level_in;
    end
  end

  assign rise_out = level_in & ~r_level_q;

endmodule

// File: rtl/mem_step_checker.sv
// Stepped memory pattern checker. Each slow-clock tick reads one memory
// word, compares it with (address XOR SEED) and records mismatches.
//   CLK            : system clock, rising edge
//   rst_n          : synchronous active-low reset
//   slow_clk       : divided step clock, synchronous to CLK, resets high
//   start          : one-cycle pulse, begins a sweep when not busy
//   abort          : one-cycle pulse, cancels a running sweep
//   mem_rdata      : read data from the memory under check
//   mem_en         : one-cycle read strobe
//   mem_addr       : read address
//   busy           : sweep in progress
//   done           : sweep completed (level)
//   pass           : valid with done, high when no mismatch was seen
//   err_count      : mismatches in the current or last sweep
//   first_err_addr : address of the first mismatch, 0 if none
//   cur_data       : last word sampled
module mem_step_checker
  import mem_check_pkg::*;
#(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] cur_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_lat_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W:0]     r_err_count;
  logic [ADDR_W-1:0]   r_first_err_addr;
  logic [DATA_W-1:0]   r_cur_data;
  logic                r_pass;

  logic                w_tick;
  logic                w_lat_last;
  logic                w_last_addr;
  logic                w_start_ok;
  logic                w_do_check;
  logic [DATA_W-1:0]   w_expected;
  logic                w_mismatch;

  tick_edge u_tick_edge (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .level_in (slow_clk),
    .rise_out (w_tick)
  );

  assign w_lat_last  = (r_lat_cnt == LAT_LAST);
  assign w_last_addr = (r_mem_addr == LAST_ADDR);
  assign w_expected  = DATA_W'(r_mem_addr) ^ SEED;
  assign w_mismatch  = (mem_rdata != w_expected);

  // A sweep can only be (re)started from a non-busy state, and abort in
  // the same cycle suppresses it.
  assign w_start_ok  = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  // An abort landing in CHECK cancels the compare of that word too.
  assign w_do_check  = (r_state == ST_CHECK) & ~abort;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ticks are only consumed in WAIT_TICK; any edge seen in READ or CHECK
  // simply falls through the case below and is lost.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_next_state = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (abort)       w_next_state = ST_IDLE;
        else if (w_tick) w_next_state = ST_READ;
      end
      ST_READ: begin
        if (abort)           w_next_state = ST_IDLE;
        else if (w_lat_last) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)            w_next_state = ST_IDLE;
        else if (w_last_addr) w_next_state = ST_DONE;
        else                  w_next_state = ST_WAIT_TICK;
      end
      ST_DONE: begin
        if (w_start_ok) w_next_state = ST_WAIT_TICK;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Counts the cycles spent in READ; it parks at zero elsewhere so every
  // entry into READ starts a fresh RD_LAT-cycle wait.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (r_state != ST_READ) begin
      r_lat_cnt <= '0;
    end else if (!w_lat_last) begin
      r_lat_cnt <= r_lat_cnt + 2'd1;
    end
  end

  // Sweep datapath. err_count cannot overflow: it is cleared at every start
  // and at most 2^ADDR_W words are compared per sweep. The address stops at
  // the last word instead of wrapping.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_mem_addr       <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_cur_data       <= '0;
      r_pass           <= 1'b0;
    end else if (w_start_ok) begin
      r_mem_addr       <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_pass           <= 1'b0;
    end else if (w_do_check) begin
      r_cur_data <= mem_rdata;
      if (w_mismatch) begin
        r_err_count <= r_err_count + (ADDR_W+1)'(1);
        if (r_err_count == '0) begin
          r_first_err_addr <= r_mem_addr;
        end
      end
      if (w_last_addr) begin
        r_pass <= (r_err_count == '0) & ~w_mismatch;
      end else begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
      end
    end
  end

  assign mem_en         = (r_state == ST_READ) & (r_lat_cnt == 2'd0);
  assign busy           = (r_state == ST_WAIT_TICK) | (r_state == ST_READ) | (r_state == ST_CHECK);
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign mem_addr       = r_mem_addr;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign cur_data       = r_cur_data;

endmodule
